// File: rtl/debouncer_pkg.sv
// Shared state encoding and width helper for the multi-channel push-button debouncer.
package debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // $clog2 clamped to at least one bit so degenerate counters still have a legal width
    function automatic int width_of(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debouncer_multi_channel.sv
// One button channel: polarity fix, 2-FF synchroniser, press/release debounce FSM and long-press timer.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int LONG_CYCLES     = 1000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = width_of(DEBOUNCE_CYCLES);
    localparam int HW = width_of(LONG_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 1);

    logic          s1, s2;
    state_t        state;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // hcnt keeps its value through RELEASE_WAIT so a bounce back to HELD cannot re-arm long_pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s2) begin
                        state <= ST_PRESS_WAIT;
                        dcnt  <= DW'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s2) begin
                        state <= ST_IDLE;
                    end else if (dcnt == D_LAST) begin
                        state       <= ST_HELD;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        hcnt        <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!s2) begin
                        state <= ST_RELEASE_WAIT;
                        dcnt  <= DW'(1);
                    end else if (hcnt != H_MAX) begin
                        hcnt       <= hcnt + 1'b1;
                        long_pulse <= (hcnt == H_PRE);
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s2) begin
                        state <= ST_HELD;
                    end else if (dcnt == D_LAST) begin
                        state         <= ST_IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// N independent debounced button channels with press, release and long-press pulses.
module debouncer_multi #(
    parameter int              N_CH            = 4,
    parameter int              DEBOUNCE_CYCLES = 10,
    parameter int              LONG_CYCLES     = 1000,
    parameter logic [N_CH-1:0] ACTIVE_LOW      = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("debouncer_multi: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("debouncer_multi: LONG_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW[i])
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .btn_in       (btn_in[i]),
            .btn_level    (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with N_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=4'b1000.
module tb_debouncer_multi;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;

    int checks = 0;
    int passed = 0;

    debouncer_multi #(
        .N_CH           (4),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .ACTIVE_LOW     (4'b1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] value);
        btn_in = value;
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string tag, input string what,
                            input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s %s: observed %b expected %b", tag, what, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                               input logic [3:0] rel, input logic [3:0] lng);
        checkOne(tag, "btn_level", btn_level, lvl);
        checkOne(tag, "press_pulse", press_pulse, prs);
        checkOne(tag, "release_pulse", release_pulse, rel);
        checkOne(tag, "long_pulse", long_pulse, lng);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'b1000);
        tick(2);
        checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        tick(2);
        checkOutput("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("[TB] clean press on channel 0");
        applyStimulus(4'b1001);
        tick(5);
        checkOutput("press0_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("press0_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("press0_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

        $display("[TB] release bounce on channel 0");
        applyStimulus(4'b1000);
        tick(2);
        checkOutput("bounce_low", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b1001);
        tick(1);
        checkOutput("bounce_high", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b1000);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("bounce_settle", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        checkOutput("release0_edge", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(1);
        checkOutput("release0_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("[TB] glitch on channel 1");
        applyStimulus(4'b1010);
        tick(3);
        applyStimulus(4'b1000);
        for (int i = 0; i < 6; i++) begin
            checkOutput("glitch1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            tick(1);
        end

        $display("[TB] long press on channel 2");
        applyStimulus(4'b1100);
        tick(5);
        checkOutput("press2_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("press2_edge", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            checkOutput("long2_wait", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        checkOutput("long2_edge", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            checkOutput("long2_once", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1000);
        tick(5);
        checkOutput("release2_wait", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("release2_edge", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        tick(1);

        $display("[TB] short hold on channel 2");
        applyStimulus(4'b1100);
        tick(6);
        checkOutput("short2_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        tick(6);
        applyStimulus(4'b1000);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("short2_hold", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        checkOutput("short2_release", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("short2_nolong", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        $display("[TB] active-low channel 3 alongside channel 1");
        applyStimulus(4'b1010);
        tick(2);
        applyStimulus(4'b0010);
        tick(3);
        checkOutput("conc_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("conc_press1", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("conc_between", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("conc_press3", 4'b1010, 4'b1000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("conc_held", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b1000);
        tick(5);
        checkOutput("conc_rel_wait", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("conc_release", 4'b0000, 4'b0000, 4'b1010, 4'b0000);
        tick(1);
        checkOutput("conc_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("[TB] reset during hold on channel 0");
        applyStimulus(4'b1001);
        tick(6);
        checkOutput("rst_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(6);
        checkOutput("rst_held", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        checkOutput("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("rst_redebounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        checkOutput("rst_repress", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("rst_reheld", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
